// File: rtl/axi_arbiter.sv
// Fixed-priority arbiter merging icache/dcache/confreg AXI traffic onto one master port.
// One outstanding read and one outstanding write; each channel stays locked to its grantee until done.
module axi_arbiter (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] i_araddr,
    input  logic [7:0]  i_arlen,
    input  logic [2:0]  i_arsize,
    input  logic        i_arvalid,
    output logic        i_arready,
    output logic        i_rvalid,
    input  logic        i_rready,
    input  logic [31:0] d_araddr,
    input  logic [7:0]  d_arlen,
    input  logic [2:0]  d_arsize,
    input  logic        d_arvalid,
    output logic        d_arready,
    output logic        d_rvalid,
    input  logic        d_rready,
    input  logic [31:0] c_araddr,
    input  logic [7:0]  c_arlen,
    input  logic [2:0]  c_arsize,
    input  logic        c_arvalid,
    output logic        c_arready,
    output logic        c_rvalid,
    input  logic        c_rready,
    output logic [31:0] src_rdata,
    output logic        src_rlast,
    input  logic [31:0] d_awaddr,
    input  logic [7:0]  d_awlen,
    input  logic [2:0]  d_awsize,
    input  logic        d_awvalid,
    output logic        d_awready,
    input  logic [31:0] d_wdata,
    input  logic [3:0]  d_wstrb,
    input  logic        d_wlast,
    input  logic        d_wvalid,
    output logic        d_wready,
    output logic        d_bvalid,
    input  logic        d_bready,
    input  logic [31:0] c_awaddr,
    input  logic [7:0]  c_awlen,
    input  logic [2:0]  c_awsize,
    input  logic        c_awvalid,
    output logic        c_awready,
    input  logic [31:0] c_wdata,
    input  logic [3:0]  c_wstrb,
    input  logic        c_wlast,
    input  logic        c_wvalid,
    output logic        c_wready,
    output logic        c_bvalid,
    input  logic        c_bready,
    output logic [3:0]  arid,
    output logic [31:0] araddr,
    output logic [7:0]  arlen,
    output logic [2:0]  arsize,
    output logic [1:0]  arburst,
    output logic        arvalid,
    input  logic        arready,
    input  logic [3:0]  rid,
    input  logic [31:0] rdata,
    input  logic [1:0]  rresp,
    input  logic        rlast,
    input  logic        rvalid,
    output logic        rready,
    output logic [3:0]  awid,
    output logic [31:0] awaddr,
    output logic [7:0]  awlen,
    output logic [2:0]  awsize,
    output logic [1:0]  awburst,
    output logic        awvalid,
    input  logic        awready,
    output logic [3:0]  wid,
    output logic [31:0] wdata,
    output logic [3:0]  wstrb,
    output logic        wlast,
    output logic        wvalid,
    input  logic        wready,
    input  logic [3:0]  bid,
    input  logic [1:0]  bresp,
    input  logic        bvalid,
    output logic        bready
);

    typedef enum logic {R_IDLE, R_BUSY} r_state_t;
    typedef enum logic {W_IDLE, W_BUSY} w_state_t;

    r_state_t    r_rstate;
    w_state_t    r_wstate;
    logic [2:0]  r_rgnt;        // {confreg, dcache, icache}
    logic [1:0]  r_wgnt;        // {confreg, dcache}
    logic [31:0] r_awaddr_lat;

    logic [2:0]  w_rwin;
    logic [31:0] w_rwin_addr;
    logic [1:0]  w_wwin;
    logic [31:0] w_wwin_addr;
    logic        w_hazard;
    logic        w_unused_ok;

    always_comb begin
        w_rwin      = 3'b000;
        w_rwin_addr = 32'd0;
        if (c_arvalid) begin
            w_rwin      = 3'b100;
            w_rwin_addr = c_araddr;
        end else if (d_arvalid) begin
            w_rwin      = 3'b010;
            w_rwin_addr = d_araddr;
        end else if (i_arvalid) begin
            w_rwin      = 3'b001;
            w_rwin_addr = i_araddr;
        end
        w_wwin      = 2'b00;
        w_wwin_addr = 32'd0;
        if (c_awvalid) begin
            w_wwin      = 2'b10;
            w_wwin_addr = c_awaddr;
        end else if (d_awvalid) begin
            w_wwin      = 2'b01;
            w_wwin_addr = d_awaddr;
        end
        // A read may not overtake a write to the same 32-byte line, whether in flight or being granted now.
        w_hazard = ((r_wstate == W_BUSY) && (w_rwin_addr[31:5] == r_awaddr_lat[31:5])) ||
                   ((r_wstate == W_IDLE) && (|w_wwin) && (w_rwin_addr[31:5] == w_wwin_addr[31:5]));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rstate <= R_IDLE;
            r_rgnt   <= 3'b000;
        end else begin
            case (r_rstate)
                R_IDLE: if (|w_rwin && !w_hazard) begin
                    r_rgnt   <= w_rwin;
                    r_rstate <= R_BUSY;
                end
                R_BUSY: if (rvalid && rready && rlast) begin
                    r_rgnt   <= 3'b000;
                    r_rstate <= R_IDLE;
                end
                default: r_rstate <= R_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wstate     <= W_IDLE;
            r_wgnt       <= 2'b00;
            r_awaddr_lat <= 32'd0;
        end else begin
            case (r_wstate)
                W_IDLE: if (|w_wwin) begin
                    r_wgnt       <= w_wwin;
                    r_awaddr_lat <= w_wwin_addr;
                    r_wstate     <= W_BUSY;
                end
                W_BUSY: if (bvalid && bready) begin
                    r_wgnt   <= 2'b00;
                    r_wstate <= W_IDLE;
                end
                default: r_wstate <= W_IDLE;
            endcase
        end
    end

    assign arid    = r_rgnt[2] ? 4'd2 : (r_rgnt[1] ? 4'd1 : 4'd0);
    assign araddr  = ({32{r_rgnt[0]}} & i_araddr) | ({32{r_rgnt[1]}} & d_araddr) | ({32{r_rgnt[2]}} & c_araddr);
    assign arlen   = ({8{r_rgnt[0]}} & i_arlen) | ({8{r_rgnt[1]}} & d_arlen) | ({8{r_rgnt[2]}} & c_arlen);
    assign arsize  = ({3{r_rgnt[0]}} & i_arsize) | ({3{r_rgnt[1]}} & d_arsize) | ({3{r_rgnt[2]}} & c_arsize);
    assign arburst = 2'b01;
    assign arvalid = |(r_rgnt & {c_arvalid, d_arvalid, i_arvalid});
    assign rready  = |(r_rgnt & {c_rready, d_rready, i_rready});

    assign i_arready = r_rgnt[0] & arready;
    assign d_arready = r_rgnt[1] & arready;
    assign c_arready = r_rgnt[2] & arready;
    assign i_rvalid  = r_rgnt[0] & rvalid;
    assign d_rvalid  = r_rgnt[1] & rvalid;
    assign c_rvalid  = r_rgnt[2] & rvalid;
    assign src_rdata = rdata;
    assign src_rlast = rlast;

    assign awid    = 4'd0;
    assign wid     = 4'd0;
    assign awburst = 2'b01;
    assign awaddr  = ({32{r_wgnt[0]}} & d_awaddr) | ({32{r_wgnt[1]}} & c_awaddr);
    assign awlen   = ({8{r_wgnt[0]}} & d_awlen) | ({8{r_wgnt[1]}} & c_awlen);
    assign awsize  = ({3{r_wgnt[0]}} & d_awsize) | ({3{r_wgnt[1]}} & c_awsize);
    assign awvalid = |(r_wgnt & {c_awvalid, d_awvalid});
    assign wdata   = ({32{r_wgnt[0]}} & d_wdata) | ({32{r_wgnt[1]}} & c_wdata);
    assign wstrb   = ({4{r_wgnt[0]}} & d_wstrb) | ({4{r_wgnt[1]}} & c_wstrb);
    assign wlast   = |(r_wgnt & {c_wlast, d_wlast});
    assign wvalid  = |(r_wgnt & {c_wvalid, d_wvalid});
    assign bready  = |(r_wgnt & {c_bready, d_bready});

    assign d_awready = r_wgnt[0] & awready;
    assign c_awready = r_wgnt[1] & awready;
    assign d_wready  = r_wgnt[0] & wready;
    assign c_wready  = r_wgnt[1] & wready;
    assign d_bvalid  = r_wgnt[0] & bvalid;
    assign c_bvalid  = r_wgnt[1] & bvalid;

    // IDs and responses from the interconnect carry no information for a single-outstanding arbiter.
    assign w_unused_ok = ^{rid, rresp, bid, bresp};

endmodule

// File: tb/tb_axi_arbiter.sv
// Directed self-checking bench for axi_arbiter: reset, read/write arbitration, line hazard, async reset.
module tb_axi_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b0;
    logic [31:0] i_araddr, d_araddr, c_araddr;
    logic [7:0]  i_arlen, d_arlen, c_arlen;
    logic [2:0]  i_arsize, d_arsize, c_arsize;
    logic        i_arvalid, d_arvalid, c_arvalid;
    logic        i_arready, d_arready, c_arready;
    logic        i_rvalid, d_rvalid, c_rvalid;
    logic        i_rready, d_rready, c_rready;
    logic [31:0] src_rdata;
    logic        src_rlast;
    logic [31:0] d_awaddr, c_awaddr, d_wdata, c_wdata;
    logic [7:0]  d_awlen, c_awlen;
    logic [2:0]  d_awsize, c_awsize;
    logic [3:0]  d_wstrb, c_wstrb;
    logic        d_awvalid, c_awvalid, d_awready, c_awready;
    logic        d_wlast, c_wlast, d_wvalid, c_wvalid, d_wready, c_wready;
    logic        d_bvalid, c_bvalid, d_bready, c_bready;
    logic [3:0]  arid, awid, wid, rid, bid;
    logic [31:0] araddr, awaddr, rdata, wdata;
    logic [7:0]  arlen, awlen;
    logic [2:0]  arsize, awsize;
    logic [1:0]  arburst, awburst, rresp, bresp;
    logic        arvalid, arready, rlast, rvalid, rready;
    logic        awvalid, awready;
    logic [3:0]  wstrb;
    logic        wlast, wvalid, wready, bvalid, bready;

    int errors = 0;
    int checks = 0;

    wire [2:0] v_arready = {c_arready, d_arready, i_arready};
    wire [2:0] v_rvalid  = {c_rvalid, d_rvalid, i_rvalid};
    wire [1:0] v_awready = {c_awready, d_awready};
    wire [1:0] v_wready  = {c_wready, d_wready};
    wire [1:0] v_bvalid  = {c_bvalid, d_bvalid};

    always #5 clk = ~clk;

    axi_arbiter dut (
        .clk(clk), .rst(rst),
        .i_araddr(i_araddr), .i_arlen(i_arlen), .i_arsize(i_arsize), .i_arvalid(i_arvalid),
        .i_arready(i_arready), .i_rvalid(i_rvalid), .i_rready(i_rready),
        .d_araddr(d_araddr), .d_arlen(d_arlen), .d_arsize(d_arsize), .d_arvalid(d_arvalid),
        .d_arready(d_arready), .d_rvalid(d_rvalid), .d_rready(d_rready),
        .c_araddr(c_araddr), .c_arlen(c_arlen), .c_arsize(c_arsize), .c_arvalid(c_arvalid),
        .c_arready(c_arready), .c_rvalid(c_rvalid), .c_rready(c_rready),
        .src_rdata(src_rdata), .src_rlast(src_rlast),
        .d_awaddr(d_awaddr), .d_awlen(d_awlen), .d_awsize(d_awsize), .d_awvalid(d_awvalid),
        .d_awready(d_awready), .d_wdata(d_wdata), .d_wstrb(d_wstrb), .d_wlast(d_wlast),
        .d_wvalid(d_wvalid), .d_wready(d_wready), .d_bvalid(d_bvalid), .d_bready(d_bready),
        .c_awaddr(c_awaddr), .c_awlen(c_awlen), .c_awsize(c_awsize), .c_awvalid(c_awvalid),
        .c_awready(c_awready), .c_wdata(c_wdata), .c_wstrb(c_wstrb), .c_wlast(c_wlast),
        .c_wvalid(c_wvalid), .c_wready(c_wready), .c_bvalid(c_bvalid), .c_bready(c_bready),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awvalid(awvalid), .awready(awready),
        .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        i_araddr = 0; d_araddr = 0; c_araddr = 0;
        i_arlen = 0; d_arlen = 0; c_arlen = 0;
        i_arsize = 3'd2; d_arsize = 3'd2; c_arsize = 3'd2;
        i_arvalid = 0; d_arvalid = 0; c_arvalid = 0;
        i_rready = 1; d_rready = 1; c_rready = 1;
        d_awaddr = 0; c_awaddr = 0; d_awlen = 0; c_awlen = 0;
        d_awsize = 3'd2; c_awsize = 3'd2; d_awvalid = 0; c_awvalid = 0;
        d_wdata = 0; c_wdata = 0; d_wstrb = 0; c_wstrb = 0;
        d_wlast = 0; c_wlast = 0; d_wvalid = 0; c_wvalid = 0;
        d_bready = 1; c_bready = 1;
        arready = 0; rid = 0; rdata = 0; rresp = 0; rlast = 0; rvalid = 0;
        awready = 0; wready = 0; bid = 0; bresp = 0; bvalid = 0;
    endtask

    task automatic apply_reset();
        rst = 1'b0;
        clear_inputs();
        tick();
        tick();
        rst = 1'b1;
        tick();
    endtask

    task automatic set_arv(input int s, input logic v);
        case (s)
            0: i_arvalid = v;
            1: d_arvalid = v;
            default: c_arvalid = v;
        endcase
    endtask

    task automatic test_reset();
        rst = 1'b0;
        clear_inputs();
        c_arvalid = 1; d_awvalid = 1; d_wvalid = 1; c_araddr = 32'h1faf_f000; d_wdata = 32'h5555_aaaa;
        tick(); tick();
        checks++; if ({arvalid, awvalid, wvalid, rready, bready} !== 5'b0) begin errors++;
            $display("FAIL reset_master_valids got=%b exp=00000", {arvalid, awvalid, wvalid, rready, bready}); end
        checks++; if ({v_arready, v_rvalid, v_awready, v_wready, v_bvalid} !== 12'b0) begin errors++;
            $display("FAIL reset_source_handshakes got=%b exp=0", {v_arready, v_rvalid, v_awready, v_wready, v_bvalid}); end
        checks++; if ({araddr, arid, awaddr, wdata, wstrb} !== 104'b0) begin errors++;
            $display("FAIL reset_muxed_data got=%h exp=0", {araddr, arid, awaddr, wdata, wstrb}); end
        rst = 1'b1;
        clear_inputs();
        tick();
    endtask

    task automatic test_confreg_read();
        apply_reset();
        c_araddr = 32'h1faf_f000; c_arlen = 0; c_arsize = 3'd2; c_arvalid = 1;
        #1;
        checks++; if (arvalid !== 1'b0) begin errors++;
            $display("FAIL cread_idle_latency got=%b exp=0", arvalid); end
        tick();
        checks++; if ({arvalid, arid, araddr, arlen, arsize, arburst} !== {1'b1, 4'd2, 32'h1faf_f000, 8'd0, 3'd2, 2'b01}) begin errors++;
            $display("FAIL cread_ar got=%h exp=%h", {arvalid, arid, araddr, arlen, arsize, arburst},
                     {1'b1, 4'd2, 32'h1faf_f000, 8'd0, 3'd2, 2'b01}); end
        arready = 1; #1;
        checks++; if (v_arready !== 3'b100) begin errors++;
            $display("FAIL cread_arready got=%b exp=100", v_arready); end
        tick();
        c_arvalid = 0; arready = 0; rvalid = 1; rdata = 32'h1234_5678; rlast = 1; #1;
        checks++; if ({v_rvalid, src_rdata, src_rlast, rready} !== {3'b100, 32'h1234_5678, 1'b1, 1'b1}) begin errors++;
            $display("FAIL cread_r got=%h exp=%h", {v_rvalid, src_rdata, src_rlast, rready}, {3'b100, 32'h1234_5678, 1'b1, 1'b1}); end
        tick();
        rvalid = 0; rlast = 0; d_araddr = 32'h200; d_arvalid = 1; #1;
        checks++; if ({arvalid, v_rvalid, rready} !== 5'b0) begin errors++;
            $display("FAIL cread_back_idle got=%b exp=00000", {arvalid, v_rvalid, rready}); end
        tick();
        checks++; if ({arvalid, arid} !== {1'b1, 4'd1}) begin errors++;
            $display("FAIL cread_next_grant got=%h exp=%h", {arvalid, arid}, {1'b1, 4'd1}); end
    endtask

    task automatic test_contention();
        int ids[4] = '{2, 1, 0, 1};
        int lens[4] = '{0, 0, 7, 0};
        logic [31:0] addrs[4] = '{32'h1faf_f000, 32'h200, 32'h100, 32'h300};
        apply_reset();
        i_araddr = 32'h100; i_arlen = 8'd7; i_arvalid = 1;
        d_araddr = 32'h200; d_arvalid = 1;
        c_araddr = 32'h1faf_f000; c_arvalid = 1;
        #1;
        checks++; if (arvalid !== 1'b0) begin errors++;
            $display("FAIL cont_idle got=%b exp=0", arvalid); end
        for (int k = 0; k < 4; k++) begin
            tick();
            checks++; if ({arvalid, arid, araddr, arlen} !== {1'b1, 4'(ids[k]), addrs[k], 8'(lens[k])}) begin errors++;
                $display("FAIL cont_grant%0d got=%h exp=%h", k, {arvalid, arid, araddr, arlen},
                         {1'b1, 4'(ids[k]), addrs[k], 8'(lens[k])}); end
            arready = 1; #1;
            checks++; if (v_arready !== 3'(1 << ids[k])) begin errors++;
                $display("FAIL cont_arready%0d got=%b exp=%b", k, v_arready, 3'(1 << ids[k])); end
            tick();
            set_arv(ids[k], 1'b0);
            arready = 0;
            for (int b = 0; b <= lens[k]; b++) begin
                rvalid = 1; rdata = 32'ha000_0000 + 32'(b); rlast = (b == lens[k]);
                if (k == 2 && b == 3) begin
                    d_araddr = 32'h300; d_arvalid = 1;
                end
                #1;
                checks++; if (v_rvalid !== 3'(1 << ids[k])) begin errors++;
                    $display("FAIL cont_rvalid%0d_%0d got=%b exp=%b", k, b, v_rvalid, 3'(1 << ids[k])); end
                if (k == 2 && b >= 3) begin
                    checks++; if ({arvalid, v_arready} !== 4'b0) begin errors++;
                        $display("FAIL cont_locked_beat%0d got=%b exp=0000", b, {arvalid, v_arready}); end
                end
                tick();
            end
            rvalid = 0; rlast = 0; #1;
            checks++; if ({arvalid, v_rvalid} !== 4'b0) begin errors++;
                $display("FAIL cont_gap%0d got=%b exp=0000", k, {arvalid, v_rvalid}); end
        end
    endtask

    task automatic test_write();
        apply_reset();
        c_awaddr = 32'h1faf_f010; c_wdata = 32'hdead_beef; c_wstrb = 4'b0011; c_wlast = 1;
        c_awvalid = 1; c_wvalid = 1;
        d_awaddr = 32'h1000; d_wdata = 32'h1111_2222; d_wstrb = 4'hf; d_wlast = 1;
        d_awvalid = 1; d_wvalid = 1;
        #1;
        checks++; if (awvalid !== 1'b0) begin errors++;
            $display("FAIL wr_idle got=%b exp=0", awvalid); end
        tick();
        checks++; if ({awvalid, awid, awaddr, awburst} !== {1'b1, 4'd0, 32'h1faf_f010, 2'b01}) begin errors++;
            $display("FAIL wr_aw got=%h exp=%h", {awvalid, awid, awaddr, awburst}, {1'b1, 4'd0, 32'h1faf_f010, 2'b01}); end
        awready = 1; #1;
        checks++; if (v_awready !== 2'b10) begin errors++;
            $display("FAIL wr_awready got=%b exp=10", v_awready); end
        tick();
        c_awvalid = 0; awready = 0;
        checks++; if ({wvalid, wid, wdata, wstrb, wlast} !== {1'b1, 4'd0, 32'hdead_beef, 4'b0011, 1'b1}) begin errors++;
            $display("FAIL wr_w got=%h exp=%h", {wvalid, wid, wdata, wstrb, wlast}, {1'b1, 4'd0, 32'hdead_beef, 4'b0011, 1'b1}); end
        wready = 1; #1;
        checks++; if (v_wready !== 2'b10) begin errors++;
            $display("FAIL wr_wready got=%b exp=10", v_wready); end
        tick();
        c_wvalid = 0; wready = 0; bvalid = 1; #1;
        checks++; if ({v_bvalid, bready, awvalid} !== 4'b1010) begin errors++;
            $display("FAIL wr_b got=%b exp=1010", {v_bvalid, bready, awvalid}); end
        tick();
        bvalid = 0; #1;
        checks++; if ({awvalid, v_bvalid} !== 3'b0) begin errors++;
            $display("FAIL wr_gap got=%b exp=000", {awvalid, v_bvalid}); end
        tick();
        checks++; if ({awvalid, awaddr, wdata, wstrb} !== {1'b1, 32'h1000, 32'h1111_2222, 4'hf}) begin errors++;
            $display("FAIL wr_dgrant got=%h exp=%h", {awvalid, awaddr, wdata, wstrb}, {1'b1, 32'h1000, 32'h1111_2222, 4'hf}); end
        bvalid = 1; #1;
        checks++; if (v_bvalid !== 2'b01) begin errors++;
            $display("FAIL wr_dbvalid got=%b exp=01", v_bvalid); end
        tick();
        bvalid = 0;
    endtask

    task automatic test_hazard();
        apply_reset();
        d_awaddr = 32'h1040; d_wdata = 32'hcafe_0001; d_wstrb = 4'hf; d_wlast = 1; d_awvalid = 1; d_wvalid = 1;
        i_araddr = 32'h2000; i_arvalid = 1;
        tick();
        checks++; if ({awvalid, awaddr, arvalid, arid, araddr} !== {1'b1, 32'h1040, 1'b1, 4'd0, 32'h2000}) begin errors++;
            $display("FAIL haz_other_line got=%h exp=%h", {awvalid, awaddr, arvalid, arid, araddr},
                     {1'b1, 32'h1040, 1'b1, 4'd0, 32'h2000}); end

        apply_reset();
        d_awaddr = 32'h1040; d_wdata = 32'hcafe_0002; d_wstrb = 4'hf; d_wlast = 1; d_awvalid = 1; d_wvalid = 1;
        d_araddr = 32'h1044; d_arvalid = 1;
        tick();
        checks++; if ({awvalid, arvalid} !== 2'b10) begin errors++;
            $display("FAIL haz_same_cycle got=%b exp=10", {awvalid, arvalid}); end
        awready = 1;
        tick();
        d_awvalid = 0; awready = 0; wready = 1;
        tick();
        d_wvalid = 0; wready = 0; i_araddr = 32'h2000; i_arvalid = 1;
        tick();
        checks++; if (arvalid !== 1'b0) begin errors++;
            $display("FAIL haz_no_fallback got=%b exp=0", arvalid); end
        bvalid = 1; #1;
        checks++; if ({v_bvalid, arvalid} !== 3'b010) begin errors++;
            $display("FAIL haz_b got=%b exp=010", {v_bvalid, arvalid}); end
        tick();
        bvalid = 0; #1;
        checks++; if (arvalid !== 1'b0) begin errors++;
            $display("FAIL haz_after_b got=%b exp=0", arvalid); end
        tick();
        checks++; if ({arvalid, arid, araddr} !== {1'b1, 4'd1, 32'h1044}) begin errors++;
            $display("FAIL haz_release got=%h exp=%h", {arvalid, arid, araddr}, {1'b1, 4'd1, 32'h1044}); end
    endtask

    task automatic test_async_reset();
        apply_reset();
        i_araddr = 32'h40; i_arlen = 8'd3; i_arvalid = 1;
        tick();
        checks++; if ({arvalid, arid, arlen} !== {1'b1, 4'd0, 8'd3}) begin errors++;
            $display("FAIL ares_grant got=%h exp=%h", {arvalid, arid, arlen}, {1'b1, 4'd0, 8'd3}); end
        arready = 1;
        tick();
        i_arvalid = 0; arready = 0;
        rvalid = 1; rdata = 32'h0; rlast = 0;
        tick();
        rdata = 32'h1;
        tick();
        rdata = 32'h2; #1;
        checks++; if ({v_rvalid, rready} !== 4'b0011) begin errors++;
            $display("FAIL ares_beat3 got=%b exp=0011", {v_rvalid, rready}); end
        #2 rst = 1'b0;
        #1;
        checks++; if ({arvalid, rready, v_rvalid, v_arready, araddr, arlen} !== 48'b0) begin errors++;
            $display("FAIL ares_clear got=%h exp=0", {arvalid, rready, v_rvalid, v_arready, araddr, arlen}); end
        rvalid = 0;
        tick();
        rst = 1'b1;
        i_araddr = 32'h80; i_arlen = 0; i_arvalid = 1;
        tick();
        checks++; if ({arvalid, arid, araddr} !== {1'b1, 4'd0, 32'h80}) begin errors++;
            $display("FAIL ares_regrant got=%h exp=%h", {arvalid, arid, araddr}, {1'b1, 4'd0, 32'h80}); end
    endtask

    initial begin
        clear_inputs();
        test_reset();
        test_confreg_read();
        test_contention();
        test_write();
        test_hazard();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
